// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register busy scoreboard.
// Combinational reads with optional same-cycle write forwarding, an optional
// hard-wired zero register, and a registered count of outstanding producers.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pendingCount
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W:0]   countNext;
    logic              wrEn;
    logic              setEn;

    // Register 0 is neither writable nor trackable when it is hard-wired to zero.
    always_comb begin
        wrEn  = RegWrite && !(ZERO_REG && (writeReg == '0));
        setEn = issueValid && !(ZERO_REG && (issueReg == '0));
    end

    // Next busy vector: clear on writeback, then set on issue so a newer producer wins.
    always_comb begin
        busyNext = busy;
        if (RegWrite) begin
            busyNext[writeReg] = 1'b0;
        end
        if (setEn) begin
            busyNext[issueReg] = 1'b1;
        end
    end

    // Population count of the next busy vector; cannot exceed DEPTH, so never wraps.
    always_comb begin
        countNext = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            countNext = countNext + {{ADDR_W{1'b0}}, busyNext[i]};
        end
    end

    // Data storage: reset clears everything and drops any concurrent write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[writeReg] <= writeData;
        end
    end

    // Scoreboard state and pending count, both ignoring issue/writeback during reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy         <= '0;
            pendingCount <= '0;
        end else begin
            busy         <= busyNext;
            pendingCount <= countNext;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
        if (ZERO_REG && (idx == '0)) begin
            return '0;
        end else if (BYPASS && wrEn && (writeReg == idx)) begin
            return writeData;
        end else begin
            return regs[idx];
        end
    endfunction

    // Read ports: zero register, then forwarded writeback, then stored value.
    always_comb begin
        readData1 = readPort(readReg1);
        readData2 = readPort(readReg2);
    end

    // Busy outputs: a forwarded writeback hides the pending bit it is about to clear.
    always_comb begin
        busy1 = busy[readReg1] && !(BYPASS && RegWrite && (writeReg == readReg1));
        busy2 = busy[readReg2] && !(BYPASS && RegWrite && (writeReg == readReg2));
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb.
// Stimulus pushes expected values; a negedge monitor pops and compares them.
module tb_reg_file_sb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        issueValid;
    logic [4:0]  issueReg;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;

    // default instance (BYPASS=1, ZERO_REG=1)
    logic [31:0] rdA1, rdA2;
    logic        bzA1, bzA2;
    logic [5:0]  pcA;
    // no-forwarding instance
    logic [31:0] rdB1, rdB2;
    logic        bzB1, bzB2;
    logic [5:0]  pcB;
    // narrow instance: DATA_W=16, ADDR_W=3, ZERO_REG=0
    logic [15:0] rdC1, rdC2;
    logic        bzC1, bzC2;
    logic [3:0]  pcC;

    reg_file_sb dutA (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .issueValid(issueValid), .issueReg(issueReg),
        .readReg1(readReg1), .readReg2(readReg2), .readData1(rdA1), .readData2(rdA2),
        .busy1(bzA1), .busy2(bzA2), .pendingCount(pcA)
    );

    reg_file_sb #(.BYPASS(1'b0)) dutB (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .issueValid(issueValid), .issueReg(issueReg),
        .readReg1(readReg1), .readReg2(readReg2), .readData1(rdB1), .readData2(rdB2),
        .busy1(bzB1), .busy2(bzB2), .pendingCount(pcB)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dutC (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .writeReg(writeReg[2:0]),
        .writeData(writeData[15:0]), .issueValid(issueValid), .issueReg(issueReg[2:0]),
        .readReg1(readReg1[2:0]), .readReg2(readReg2[2:0]), .readData1(rdC1), .readData2(rdC2),
        .busy1(bzC1), .busy2(bzC2), .pendingCount(pcC)
    );

    always #5 CLK = ~CLK;

    localparam int A_RD1 = 0, A_RD2 = 1, A_BZ1 = 2, A_BZ2 = 3, A_PC = 4;
    localparam int B_RD1 = 5, B_BZ1 = 6, B_PC = 7;
    localparam int C_RD1 = 8, C_PC = 9, C_BZ1 = 10;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            A_RD1:   return rdA1;
            A_RD2:   return rdA2;
            A_BZ1:   return {31'b0, bzA1};
            A_BZ2:   return {31'b0, bzA2};
            A_PC:    return {26'b0, pcA};
            B_RD1:   return rdB1;
            B_BZ1:   return {31'b0, bzB1};
            B_PC:    return {26'b0, pcB};
            C_RD1:   return {16'b0, rdC1};
            C_PC:    return {28'b0, pcC};
            C_BZ1:   return {31'b0, bzC1};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: every falling edge, compare all queued expectations for this cycle.
    initial begin
        chk_t c;
        logic [31:0] got;
        forever begin
            @(negedge CLK);
            while (expQ.size() != 0) begin
                c   = expQ.pop_front();
                got = actual(c.sig);
                total++;
                if (got !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
                end
            end
        end
    end

    task automatic chk(input int sig, input logic [31:0] e, input string n);
        expQ.push_back('{sig: sig, exp: e, name: n});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; RegWrite = 1'b0; issueValid = 1'b0;
        writeReg = '0; writeData = '0; issueReg = '0;
    endtask

    initial begin
        idle();
        RST = 1'b1; readReg1 = 5'd5; readReg2 = 5'd31;
        step();
        // reset state
        idle();
        chk(A_RD1, 32'h0, "reset rd1");
        chk(A_RD2, 32'h0, "reset rd2");
        chk(A_BZ1, 32'h0, "reset busy1");
        chk(A_PC,  32'h0, "reset count");

        // write with forwarding vs without
        step();
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF; readReg1 = 5'd5;
        chk(A_RD1, 32'hDEADBEEF, "bypass same cycle");
        chk(B_RD1, 32'h0,        "no-bypass old value");
        step();
        idle(); readReg2 = 5'd5;
        chk(B_RD1, 32'hDEADBEEF, "no-bypass after edge");
        chk(A_RD1, 32'hDEADBEEF, "stored rd1");
        chk(A_RD2, 32'hDEADBEEF, "same index rd2");

        // zero register
        step();
        RegWrite = 1'b1; writeReg = 5'd0; writeData = 32'h12345678;
        issueValid = 1'b1; issueReg = 5'd0; readReg1 = 5'd0;
        chk(A_RD1, 32'h0, "zero reg no bypass");
        chk(A_BZ1, 32'h0, "zero reg busy comb");
        step();
        idle();
        chk(A_RD1, 32'h0, "zero reg after write");
        chk(A_BZ1, 32'h0, "zero reg not busy");
        chk(A_PC,  32'h0, "zero reg count");

        // issue 3, 7, 9
        step(); issueValid = 1'b1; issueReg = 5'd3;
        step(); issueReg = 5'd7;
        chk(A_PC, 32'd1, "count after 3");
        step(); issueReg = 5'd9;
        chk(A_PC, 32'd2, "count after 7");
        step(); idle(); readReg1 = 5'd3; readReg2 = 5'd7;
        chk(A_PC,  32'd3, "count after 9");
        chk(A_BZ1, 32'h1, "busy 3");
        chk(A_BZ2, 32'h1, "busy 7");
        step(); readReg1 = 5'd9;
        chk(A_BZ1, 32'h1, "busy 9");
        step();
        RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h77;
        chk(A_BZ2, 32'h0,  "busy 7 masked by writeback");
        chk(A_RD2, 32'h77, "writeback 7 forwarded");
        step(); idle();
        chk(A_PC,  32'd2,  "count after clear 7");
        chk(A_BZ2, 32'h0,  "busy 7 cleared");
        chk(A_RD2, 32'h77, "data 7 stored");

        // writeback to a register with no pending producer
        step(); RegWrite = 1'b1; writeReg = 5'd12; writeData = 32'hC;
        step(); idle(); readReg2 = 5'd12;
        chk(A_PC,  32'd2, "count unchanged non-busy write");
        chk(A_RD2, 32'hC, "non-busy write data");
        chk(A_BZ2, 32'h0, "non-busy stays clear");

        // simultaneous issue and writeback on register 4
        step(); issueValid = 1'b1; issueReg = 5'd4;
        step(); idle();
        chk(A_PC, 32'd3, "count after issue 4");
        step();
        issueValid = 1'b1; issueReg = 5'd4;
        RegWrite = 1'b1; writeReg = 5'd4; writeData = 32'h44; readReg1 = 5'd4;
        chk(A_BZ1, 32'h0, "busy 4 masked during writeback");
        chk(B_BZ1, 32'h1, "no-bypass busy 4 unmasked");
        step(); idle();
        chk(A_BZ1, 32'h1,  "busy 4 set wins");
        chk(A_PC,  32'd3,  "count unchanged set+clear");
        chk(A_RD1, 32'h44, "data 4 written");

        // reset in mid-operation with a concurrent write and issue
        step(); issueValid = 1'b1; issueReg = 5'd10;
        step(); issueReg = 5'd11;
        step(); idle();
        chk(A_PC, 32'd5, "count five busy");
        step();
        RST = 1'b1; RegWrite = 1'b1; writeReg = 5'd13; writeData = 32'hBAD;
        issueValid = 1'b1; issueReg = 5'd14;
        step(); idle(); readReg1 = 5'd13; readReg2 = 5'd5;
        chk(A_RD1, 32'h0, "write dropped in reset");
        chk(A_RD2, 32'h0, "data 5 cleared");
        chk(A_PC,  32'h0, "count cleared");
        chk(B_PC,  32'h0, "no-bypass count cleared");
        step(); readReg1 = 5'd4; readReg2 = 5'd14;
        chk(A_RD1, 32'h0, "data 4 cleared");
        chk(A_BZ1, 32'h0, "busy 4 cleared");
        chk(A_BZ2, 32'h0, "issue dropped in reset");

        // narrow instance: 8 registers, index 0 usable
        step();
        RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h0000A5A5; readReg1 = 5'd7;
        chk(C_RD1, 32'hA5A5, "narrow bypass idx7");
        step(); idle();
        chk(C_RD1, 32'hA5A5, "narrow stored idx7");
        for (int i = 0; i < 8; i++) begin
            step();
            issueValid = 1'b1; issueReg = 5'(i);
            if (i > 0) chk(C_PC, 32'(i), "narrow count ramp");
        end
        step(); issueReg = 5'd7;
        chk(C_PC, 32'd8, "narrow count full");
        step(); idle(); readReg1 = 5'd0;
        chk(C_PC,  32'd8, "narrow count no overflow");
        chk(C_BZ1, 32'h1, "narrow idx0 busy");
        step(); RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'h3;
        step(); idle();
        chk(C_PC, 32'd7, "narrow count after clear");

        step();
        step();
        if (expQ.size() != 0) begin
            $display("FAIL drain: got %0d unchecked expected 0", expQ.size());
            bad += expQ.size();
            total += expQ.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
